// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the parametrised ARM register file.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_NREAD = 2;

  typedef logic [DEFAULT_WIDTH-1:0] reg_word_t;

  // Address width for a register count, never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mux_n1_var.sv
// Generic N:1 mux built as per-bit AND-OR columns; a select at or above N yields zero.
module mux_n1_var #(
  parameter int WIDTH = 64,
  parameter int N     = 32,
  parameter int SEL_W = (N <= 1) ? 1 : $clog2(N)
) (
  input  logic [N-1:0][WIDTH-1:0] data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        y
);

  logic [N-1:0] onehot;

  // Out-of-range selects simply leave the one-hot vector empty.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [N-1:0] column;
      for (gj = 0; gj < N; gj++) begin : g_col
        assign column[gj] = data[gj][gi];
      end
      assign y[gi] = |(column & onehot);
    end
  endgenerate

endmodule

// File: rtl/regfile_var.sv
// Parametrised register file: NREAD combinational read ports, one clocked write port,
// optional hardwired-zero top register and same-cycle write-to-read bypass.
module regfile_var
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NREAD    = DEFAULT_NREAD,
  parameter int ZERO_REG = 1,
  parameter int ADDR_W   = addr_width(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         RegWrite,
  input  logic [ADDR_W-1:0]            WriteRegister,
  input  logic [WIDTH-1:0]             WriteData,
  input  logic [NREAD-1:0][ADDR_W-1:0] ReadRegister,
  output logic [NREAD-1:0][WIDTH-1:0]  ReadData
);

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]             regs_reg [DEPTH];
  logic [DEPTH-1:0][WIDTH-1:0]  mux_in;
  logic [DEPTH-1:0]             we;
  logic                         write_legal;

  assign write_legal = RegWrite && !reset
                    && ({1'b0, WriteRegister} < DEPTH_X)
                    && !((ZERO_REG != 0) && (WriteRegister == LAST_REG));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we[i]) begin
          regs_reg[i] <= WriteData;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      assign we[gi] = write_legal && (WriteRegister == ADDR_W'(gi));
      // The zero register is masked at the mux input so it reads 0 even before reset.
      if ((ZERO_REG != 0) && (gi == DEPTH - 1)) begin : g_zero
        assign mux_in[gi] = '0;
      end else begin : g_store
        assign mux_in[gi] = regs_reg[gi];
      end
    end

    for (gi = 0; gi < NREAD; gi++) begin : g_port
      logic [WIDTH-1:0] stored;
      logic             bypass_hit;

      mux_n1_var #(
        .WIDTH (WIDTH),
        .N     (DEPTH),
        .SEL_W (ADDR_W)
      ) u_mux (
        .data (mux_in),
        .sel  (ReadRegister[gi]),
        .y    (stored)
      );

      // write_legal already excludes out-of-range, zero-register and reset cases.
      assign bypass_hit   = write_legal && (WriteRegister == ReadRegister[gi]);
      assign ReadData[gi] = reset      ? '0 :
                            bypass_hit ? WriteData : stored;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_var.sv
// Scoreboard bench for regfile_var across default, non-zero-register and odd-depth configurations.
module tb_regfile_var;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (64x32, 2 ports, XZR)
  logic            a_we = 1'b0;
  logic [4:0]      a_wa = '0;
  reg_word_t       a_wd = '0;
  logic [1:0][4:0] a_ra = '0;
  logic [1:0][63:0] a_rd;

  // Instance B: defaults but ZERO_REG=0
  logic            b_we = 1'b0;
  logic [4:0]      b_wa = '0;
  reg_word_t       b_wd = '0;
  logic [1:0][4:0] b_ra = '0;
  logic [1:0][63:0] b_rd;

  // Instance C: DEPTH=20, NREAD=3, WIDTH=32
  logic            c_we = 1'b0;
  logic [4:0]      c_wa = '0;
  logic [31:0]     c_wd = '0;
  logic [2:0][4:0] c_ra = '0;
  logic [2:0][31:0] c_rd;

  regfile_var u_a (
    .clk(clk), .reset(rst), .RegWrite(a_we), .WriteRegister(a_wa),
    .WriteData(a_wd), .ReadRegister(a_ra), .ReadData(a_rd)
  );

  regfile_var #(.ZERO_REG(0)) u_b (
    .clk(clk), .reset(rst), .RegWrite(b_we), .WriteRegister(b_wa),
    .WriteData(b_wd), .ReadRegister(b_ra), .ReadData(b_rd)
  );

  regfile_var #(.WIDTH(32), .DEPTH(20), .NREAD(3)) u_c (
    .clk(clk), .reset(rst), .RegWrite(c_we), .WriteRegister(c_wa),
    .WriteData(c_wd), .ReadRegister(c_ra), .ReadData(c_rd)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];
  logic [63:0] e;

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    a_we = 1'b1; a_wa = 5'd4; a_wd = 64'h1234;
    a_ra[0] = 5'd4;
    exp_q.push_back(64'h0);
    #2;
    e = exp_q.pop_front(); checks++;
    if (a_rd[0] !== e) begin
      errors++; $display("FAIL reset_bypass_suppressed got %h want %h", a_rd[0], e);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; a_we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a_ra[0] = 5'(i);
      a_ra[1] = 5'(31 - i);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (a_rd[0] !== e) begin
        errors++; $display("FAIL reset_p0 addr %0d got %h want %h", i, a_rd[0], e);
      end
      e = exp_q.pop_front(); checks++;
      if (a_rd[1] !== e) begin
        errors++; $display("FAIL reset_p1 addr %0d got %h want %h", 31 - i, a_rd[1], e);
      end
    end
    $display("reset: all 32 addresses read on both ports");
  endtask

  task automatic test_bypass();
    @(negedge clk);
    a_we = 1'b1; a_wa = 5'd5; a_wd = 64'hDEAD_BEEF_0123_4567;
    a_ra[0] = 5'd5; a_ra[1] = 5'd6;
    exp_q.push_back(64'hDEAD_BEEF_0123_4567);
    exp_q.push_back(64'h0);
    #2;
    e = exp_q.pop_front(); checks++;
    if (a_rd[0] !== e) begin
      errors++; $display("FAIL bypass got %h want %h", a_rd[0], e);
    end
    e = exp_q.pop_front(); checks++;
    if (a_rd[1] !== e) begin
      errors++; $display("FAIL bypass_other_port got %h want %h", a_rd[1], e);
    end
    @(negedge clk);
    a_we = 1'b0; a_wd = 64'h0;
    exp_q.push_back(64'hDEAD_BEEF_0123_4567);
    #2;
    e = exp_q.pop_front(); checks++;
    if (a_rd[0] !== e) begin
      errors++; $display("FAIL stored_after_write got %h want %h", a_rd[0], e);
    end
    $display("bypass: reg5 write/read same cycle and next cycle");
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    a_we = 1'b1; a_wa = 5'd31; a_wd = '1; a_ra[0] = 5'd31; a_ra[1] = 5'd31;
    b_we = 1'b1; b_wa = 5'd31; b_wd = '1; b_ra[0] = 5'd31; b_ra[1] = 5'd31;
    exp_q.push_back(64'h0);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    #2;
    e = exp_q.pop_front(); checks++;
    if (a_rd[0] !== e || a_rd[1] !== e) begin
      errors++; $display("FAIL xzr_during_write got %h/%h want %h", a_rd[0], a_rd[1], e);
    end
    e = exp_q.pop_front(); checks++;
    if (b_rd[0] !== e) begin
      errors++; $display("FAIL noxzr_bypass got %h want %h", b_rd[0], e);
    end
    @(negedge clk);
    a_we = 1'b0; b_we = 1'b0;
    exp_q.push_back(64'h0);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    #2;
    e = exp_q.pop_front(); checks++;
    if (a_rd[1] !== e) begin
      errors++; $display("FAIL xzr_after_write got %h want %h", a_rd[1], e);
    end
    e = exp_q.pop_front(); checks++;
    if (b_rd[1] !== e) begin
      errors++; $display("FAIL noxzr_retained got %h want %h", b_rd[1], e);
    end
    $display("zero_reg: reg31 write with ZERO_REG=1 and ZERO_REG=0");
  endtask

  task automatic test_multi_port();
    logic [4:0]  ra0 [3];
    logic [4:0]  ra1 [3];
    logic [63:0] ex0 [3];
    logic [63:0] ex1 [3];
    ra0 = '{5'd3, 5'd7, 5'd3}; ra1 = '{5'd7, 5'd7, 5'd3};
    ex0 = '{64'h1, 64'h2, 64'h1}; ex1 = '{64'h2, 64'h2, 64'h1};
    @(negedge clk);
    a_we = 1'b1; a_wa = 5'd3; a_wd = 64'h1;
    @(negedge clk);
    a_wa = 5'd7; a_wd = 64'h2;
    @(negedge clk);
    a_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_ra[0] = ra0[k]; a_ra[1] = ra1[k];
      exp_q.push_back(ex0[k]);
      exp_q.push_back(ex1[k]);
      #1;
      e = exp_q.pop_front(); checks++;
      if (a_rd[0] !== e) begin
        errors++; $display("FAIL multi_p0 case %0d got %h want %h", k, a_rd[0], e);
      end
      e = exp_q.pop_front(); checks++;
      if (a_rd[1] !== e) begin
        errors++; $display("FAIL multi_p1 case %0d got %h want %h", k, a_rd[1], e);
      end
    end
    $display("multi_port: {3,7} {7,7} {3,3}");
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    c_we = 1'b1; c_wa = 5'd9; c_wd = 32'h1111_1111;
    @(negedge clk);
    c_wa = 5'd25; c_wd = 32'hA5A5_A5A5; c_ra[2] = 5'd25;
    exp_q.push_back(64'h0);
    #2;
    e = exp_q.pop_front(); checks++;
    if (64'(c_rd[2]) !== e) begin
      errors++; $display("FAIL oor_bypass got %h want %h", c_rd[2], e);
    end
    @(negedge clk);
    c_wa = 5'd19; c_wd = 32'hCAFE_F00D;
    @(negedge clk);
    c_we = 1'b0;
    c_ra[0] = 5'd9; c_ra[1] = 5'd25; c_ra[2] = 5'd19;
    exp_q.push_back(64'h1111_1111);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (64'(c_rd[0]) !== e) begin
      errors++; $display("FAIL oor_no_alias_reg9 got %h want %h", c_rd[0], e);
    end
    e = exp_q.pop_front(); checks++;
    if (64'(c_rd[1]) !== e) begin
      errors++; $display("FAIL oor_read25 got %h want %h", c_rd[1], e);
    end
    e = exp_q.pop_front(); checks++;
    if (64'(c_rd[2]) !== e) begin
      errors++; $display("FAIL depth20_zero_reg got %h want %h", c_rd[2], e);
    end
    for (int i = 0; i < 20; i++) begin
      c_ra[0] = 5'(i);
      exp_q.push_back((i == 9) ? 64'h1111_1111 : 64'h0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (64'(c_rd[0]) !== e) begin
        errors++; $display("FAIL oor_unchanged reg %0d got %h want %h", i, c_rd[0], e);
      end
    end
    $display("out_of_range: DEPTH=20 write to 25 ignored, regs 0..19 intact");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_we = 1'b1; a_wa = 5'd10; a_wd = 64'h77;
    @(negedge clk);
    a_we = 1'b0; a_ra[0] = 5'd10; a_ra[1] = 5'd5;
    exp_q.push_back(64'h77);
    #2;
    e = exp_q.pop_front(); checks++;
    if (a_rd[0] !== e) begin
      errors++; $display("FAIL pre_reset_reg10 got %h want %h", a_rd[0], e);
    end
    @(negedge clk);
    rst = 1'b1; a_we = 1'b1; a_wa = 5'd10; a_wd = 64'h99;
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0);
    #2;
    e = exp_q.pop_front(); checks++;
    if (a_rd[0] !== e) begin
      errors++; $display("FAIL during_reset_p0 got %h want %h", a_rd[0], e);
    end
    e = exp_q.pop_front(); checks++;
    if (a_rd[1] !== e) begin
      errors++; $display("FAIL during_reset_p1 got %h want %h", a_rd[1], e);
    end
    @(negedge clk);
    rst = 1'b0; a_we = 1'b0;
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0);
    #2;
    e = exp_q.pop_front(); checks++;
    if (a_rd[0] !== e) begin
      errors++; $display("FAIL after_reset_reg10 got %h want %h", a_rd[0], e);
    end
    e = exp_q.pop_front(); checks++;
    if (a_rd[1] !== e) begin
      errors++; $display("FAIL after_reset_reg5 got %h want %h", a_rd[1], e);
    end
    $display("reset_mid: write during reset discarded, reg10 and reg5 cleared");
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_multi_port();
    test_out_of_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
